// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V instruction-fetch slice.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int PC_W = 32;
  localparam logic [XLEN-1:0] RISCV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  // Fetch addresses are word addresses; the low two bits are forced to zero.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with a zero-latency head and a
// single-cycle flush that wins over push and pop.
module riscv_fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output fetch_entry_t     head
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign head  = mem[rd_ptr];

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests, buffers
// responses in a prefetch FIFO and hands {instr, pc} pairs to decode.
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [PC_W-1:0] dec_pc,
  output logic            fetch_fault
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e     state;
  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] drop;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   in_use;
  logic             fifo_empty;
  logic             unused_fifo_full;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;
  logic             accept;
  logic             keep;
  logic             pop;
  logic             misaligned;

  // Requests in flight plus buffered entries never exceed the FIFO depth,
  // so every response that comes back is guaranteed a slot.
  assign in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && (state == RUN) && !redirect_valid &&
                          (in_use < (CNT_W + 1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign keep       = imem_rsp_valid && !redirect_valid && (drop == '0);
  assign push_entry = '{pc: resp_pc, instr: imem_rsp_data};
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  assign dec_valid = !fifo_empty && !redirect_valid;
  assign pop       = dec_valid && dec_ready;
  assign dec_instr = fifo_empty ? RISCV_NOP : fifo_head.instr;
  assign dec_pc    = fifo_empty ? '0 : fifo_head.pc;

  always_comb begin
    outstanding_next = outstanding;
    if (accept && !imem_rsp_valid)      outstanding_next = outstanding + CNT_W'(1);
    else if (!accept && imem_rsp_valid) outstanding_next = outstanding - CNT_W'(1);
  end

  riscv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (keep),
    .wdata (push_entry),
    .pop   (pop),
    .flush (redirect_valid),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (unused_fifo_full),
    .head  (fifo_head)
  );

  // On a redirect every request still in flight becomes wrong-path and is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        fetch_pc <= word_align(redirect_pc);
        resp_pc  <= word_align(redirect_pc);
        drop     <= outstanding_next;
      end else begin
        if (accept) fetch_pc <= fetch_pc + PC_W'(4);
        if (keep)   resp_pc  <= resp_pc + PC_W'(4);
        if (imem_rsp_valid && (drop != '0)) drop <= drop - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (redirect_valid && misaligned) begin
            state       <= FAULT;
            fetch_fault <= 1'b1;
          end
        end
        FAULT: begin
          if (redirect_valid && !misaligned) begin
            state       <= RUN;
            fetch_fault <= 1'b0;
          end
        end
        default: begin
          state       <= RUN;
          fetch_fault <= 1'b0;
        end
      endcase
    end
  end

endmodule
